display_mode_ctrl: RTL and testbench

Runtime video-mode sequencer that sits between the control plane and a bank of `display_timings` generators selected by a mode mux. It accepts a mode-change request, waits for a frame boundary, blanks the output, holds the timing generator in reset while the mux switches, and waits for the new mode to settle over whole frames before signalling completion. It also runs the same reset-and-settle sequence at power-up so that downstream logic only ever sees complete frames.

---
 rtl/display_mode_ctrl.sv | 161 ++++++++++++++++
 tb/tb_display_mode_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/display_mode_ctrl.sv
// Video-mode sequencer: frame-aligned blank, timing-generator reset, mux switch and
// whole-frame settle. Runs the same reset/settle sequence after i_rst.
module display_mode_ctrl #(
  parameter int unsigned MODES         = 4,
  parameter int unsigned DEFAULT_MODE  = 0,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned TIMEOUT       = 1_000_000
) (
  input  logic       i_pix_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic [1:0] i_mode,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_err,
  output logic       o_timeout,
  input  logic       i_frame,
  output logic       o_tg_rst,
  output logic [1:0] o_mode,
  output logic       o_blank
);
  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned FRM_W = $clog2(SETTLE_FRAMES + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_RESET, ST_SETTLE, ST_IDLE, ST_ALIGN} state_e;

  state_e           state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [WD_W-1:0]  wd_cur;
  logic [1:0]       req_mode_q, req_mode_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;
  logic             tg_rst_q, tg_rst_d;
  logic             blank_q, blank_d;
  logic             accept, wd_fire;

  // Next state and next registered outputs
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    frm_cnt_d  = frm_cnt_q;
    wd_cnt_d   = '0;
    req_mode_d = req_mode_q;
    mode_d     = mode_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    timeout_d  = timeout_q;
    accept     = i_req && ready_q;
    // The cycle carrying a frame pulse counts as elapsed cycle zero
    wd_cur     = i_frame ? '0 : wd_cnt_q;
    wd_fire    = !i_frame && (wd_cur >= WD_W'(TIMEOUT - 1));

    case (state_q)
      ST_RESET: begin
        frm_cnt_d = '0;
        if (rst_cnt_q <= RST_W'(1)) begin
          state_d = ST_SETTLE;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end
      ST_SETTLE: begin
        wd_cnt_d = (wd_cur == WD_W'(TIMEOUT)) ? wd_cur : wd_cur + WD_W'(1);
        if (i_frame) begin
          if (frm_cnt_q >= FRM_W'(SETTLE_FRAMES - 1)) begin
            state_d = ST_IDLE;
          end else begin
            frm_cnt_d = frm_cnt_q + FRM_W'(1);
          end
        end else if (wd_fire) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
        if (state_d == ST_IDLE) begin
          done_d = busy_q;
          busy_d = 1'b0;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          req_mode_d = i_mode;
          timeout_d  = 1'b0;
          if (32'(i_mode) >= MODES) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (i_mode == mode_q) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ALIGN;
            busy_d  = 1'b1;
          end
        end
      end
      ST_ALIGN: begin
        wd_cnt_d = (wd_cur == WD_W'(TIMEOUT)) ? wd_cur : wd_cur + WD_W'(1);
        if (i_frame || wd_fire) begin
          state_d   = ST_RESET;
          mode_d    = req_mode_q;
          rst_cnt_d = RST_W'(RST_CYCLES);
          timeout_d = timeout_q | wd_fire;
        end
      end
      default: state_d = ST_RESET;
    endcase

    if (state_d != state_q) wd_cnt_d = '0;

    ready_d  = (state_d == ST_IDLE);
    tg_rst_d = (state_d == ST_RESET);
    blank_d  = (state_d == ST_RESET) || (state_d == ST_SETTLE);
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      state_q    <= ST_RESET;
      rst_cnt_q  <= RST_W'(RST_CYCLES);
      frm_cnt_q  <= '0;
      wd_cnt_q   <= '0;
      req_mode_q <= '0;
      mode_q     <= 2'(DEFAULT_MODE);
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      tg_rst_q   <= 1'b1;
      blank_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      req_mode_q <= req_mode_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      tg_rst_q   <= tg_rst_d;
      blank_q    <= blank_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign o_timeout = timeout_q;
  assign o_tg_rst  = tg_rst_q;
  assign o_mode    = mode_q;
  assign o_blank   = blank_q;
endmodule

// File: tb/tb_display_mode_ctrl.sv
// Bench for display_mode_ctrl: directed and random mode requests checked against a timeline model.
// u_a exercises normal switching; u_b has a short watchdog and is held in reset until u_a is done.
module tb_display_mode_ctrl;
  localparam int RST     = 4;
  localparam int SF      = 2;
  localparam int P       = 100;
  localparam int TO_A    = 1000;
  localparam int TO_B    = 50;
  localparam int MODES_A = 3;
  localparam int MODES_B = 4;
  localparam int NEVER   = 32'h3fff_ffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, req_a, ready_a, done_a, err_a, to_a, frame_a, tg_a, blank_a, gen_en_a;
  logic       rst_b, req_b, ready_b, done_b, err_b, to_b, frame_b, tg_b, blank_b, gen_en_b;
  logic [1:0] mode_in_a, mode_a, mode_in_b, mode_b;
  logic [7:0] obs_a, obs_b;
  int         fcnt_a, fcnt_b;

  display_mode_ctrl #(.MODES(MODES_A), .DEFAULT_MODE(0), .RST_CYCLES(RST),
                      .SETTLE_FRAMES(SF), .TIMEOUT(TO_A)) u_a (
    .i_pix_clk(clk), .i_rst(rst_a), .i_req(req_a), .i_mode(mode_in_a),
    .o_ready(ready_a), .o_done(done_a), .o_err(err_a), .o_timeout(to_a),
    .i_frame(frame_a), .o_tg_rst(tg_a), .o_mode(mode_a), .o_blank(blank_a));

  display_mode_ctrl #(.MODES(MODES_B), .DEFAULT_MODE(0), .RST_CYCLES(RST),
                      .SETTLE_FRAMES(SF), .TIMEOUT(TO_B)) u_b (
    .i_pix_clk(clk), .i_rst(rst_b), .i_req(req_b), .i_mode(mode_in_b),
    .o_ready(ready_b), .o_done(done_b), .o_err(err_b), .o_timeout(to_b),
    .i_frame(frame_b), .o_tg_rst(tg_b), .o_mode(mode_b), .o_blank(blank_b));

  // Timing-generator stand-ins: frame-start held while in reset, then one pulse every P cycles
  always @(posedge clk) begin
    if (tg_a !== 1'b0) fcnt_a <= 0;
    else fcnt_a <= (fcnt_a == P - 1) ? 0 : fcnt_a + 1;
    if (tg_b !== 1'b0) fcnt_b <= 0;
    else fcnt_b <= (fcnt_b == P - 1) ? 0 : fcnt_b + 1;
  end
  assign frame_a = (tg_a !== 1'b0) || (gen_en_a && fcnt_a == 0);
  assign frame_b = (tg_b !== 1'b0) || (gen_en_b && fcnt_b == 0);

  assign obs_a = {ready_a, done_a, err_a, to_a, tg_a, blank_a, mode_a};
  assign obs_b = {ready_b, done_b, err_b, to_b, tg_b, blank_b, mode_b};

  int         checks, errors, cyc, sel;
  int         m_base [2];
  logic [1:0] m_mode [2];
  logic       m_to   [2];

  function automatic logic [7:0] mk(input logic r, input logic d, input logic e, input logic t,
                                    input logic g, input logic b, input logic [1:0] m);
    return {r, d, e, t, g, b, m};
  endfunction

  function automatic logic gen_now();
    return (sel == 1) ? gen_en_b : gen_en_a;
  endfunction

  function automatic int to_now();
    return (sel == 1) ? TO_B : TO_A;
  endfunction

  // First cycle >= c carrying a frame pulse, from the model's own frame phase
  function automatic int next_frame(input int c);
    int d;
    if (!gen_now()) return NEVER;
    d = (c - m_base[sel]) % P;
    return (d == 0) ? c : c + P - d;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = (sel == 1) ? obs_b : obs_a;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d cyc=%0d observed=%b expected=%b", tag, sel, cyc, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic q, input logic [1:0] m);
    if (sel == 1) begin
      rst_b = r; req_b = q; mode_in_b = m;
    end else begin
      rst_a = r; req_a = q; mode_in_a = m;
    end
  endtask

  task automatic idle_step();
    drive(1'b0, 1'b0, 2'($urandom_range(0, 3)));
    tick();
    chk("idle", mk(1'b1, 1'b0, 1'b0, m_to[sel], 1'b0, 1'b0, m_mode[sel]));
  endtask

  // Check every cycle of a reset/settle sequence whose RESET phase starts at cycle s
  task automatic run_seq(input int s, input logic done_f, input logic align_to, input logic noise,
                         input logic [1:0] mode_old, input logic [1:0] mode_new, input int abort_off);
    int   st, idle_c, last, c;
    logic settle_to, to_e;
    logic [7:0] e;
    st = s + RST;
    if (!gen_now() || to_now() <= (SF - 1) * P) begin
      idle_c = st + to_now(); settle_to = 1'b1;
    end else begin
      idle_c = st + (SF - 1) * P + 1; settle_to = 1'b0;
    end
    last = (abort_off >= 0) ? st + abort_off : idle_c + 1;
    to_e = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      c = cyc;
      to_e = (align_to && c >= s) || (settle_to && c >= idle_c);
      if (c < s)           e = mk(1'b0, 1'b0, 1'b0, to_e, 1'b0, 1'b0, mode_old);
      else if (c < st)     e = mk(1'b0, 1'b0, 1'b0, to_e, 1'b1, 1'b1, mode_new);
      else if (c < idle_c) e = mk(1'b0, 1'b0, 1'b0, to_e, 1'b0, 1'b1, mode_new);
      else                 e = mk(1'b1, done_f && c == idle_c, 1'b0, to_e, 1'b0, 1'b0, mode_new);
      chk("seq", e);
      if (c >= last) break;
      drive(1'b0, noise && c < idle_c && $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)));
      tick();
    end
    drive(1'b0, 1'b0, 2'd0);
    m_base[sel] = st;
    m_mode[sel] = mode_new;
    m_to[sel]   = to_e;
  endtask

  task automatic request(input logic [1:0] m, input logic noise, input int abort_off);
    int a, t, s;
    logic at;
    drive(1'b0, 1'b1, m);
    tick();
    a = cyc;
    drive(1'b0, 1'b0, 2'd0);
    m_to[sel] = 1'b0;
    if (int'(m) >= ((sel == 1) ? MODES_B : MODES_A)) begin
      chk("invalid", mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m_mode[sel]));
      idle_step();
    end else if (m == m_mode[sel]) begin
      chk("same", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_mode[sel]));
      idle_step();
    end else begin
      t = next_frame(a);
      if (t - a < to_now()) begin
        s = t + 1; at = 1'b0;
      end else begin
        s = a + to_now(); at = 1'b1;
      end
      run_seq(s, 1'b1, at, noise, m_mode[sel], m, abort_off);
    end
  endtask

  task automatic power_up(input logic noise);
    drive(1'b1, 1'b0, 2'd0);
    tick();
    chk("reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
    tick();
    chk("reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
    m_to[sel] = 1'b0;
    run_seq(cyc, 1'b0, 1'b0, noise, 2'd0, 2'd0, -1);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; sel = 0;
    rst_a = 1'b1; req_a = 1'b0; mode_in_a = 2'd0; gen_en_a = 1'b1;
    rst_b = 1'b1; req_b = 1'b0; mode_in_b = 2'd0; gen_en_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_base[i] = 0; m_mode[i] = 2'd0; m_to[i] = 1'b0;
    end

    sel = 0;
    power_up(1'b1);
    repeat (5) idle_step();
    for (int k = 0; k <= P && next_frame(cyc) - cyc != 37; k++) idle_step();
    request(2'd2, 1'b1, -1);
    repeat (3) idle_step();
    request(2'd2, 1'b0, -1);
    request(2'd3, 1'b0, -1);
    request(2'd0, 1'b1, -1);
    request(2'd1, 1'b0, 30);
    drive(1'b1, 1'b0, 2'd0);
    tick();
    chk("rst_mid", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
    m_to[0] = 1'b0;
    run_seq(cyc, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, -1);
    repeat (10) begin
      repeat ($urandom_range(0, 120)) idle_step();
      request(2'($urandom_range(0, 3)), 1'b1, -1);
    end

    sel = 1;
    power_up(1'b0);
    gen_en_b = 1'b0;
    repeat (3) idle_step();
    request(2'd1, 1'b0, -1);
    request(2'd1, 1'b0, -1);
    gen_en_b = 1'b1;
    repeat (3) begin
      repeat ($urandom_range(0, 100)) idle_step();
      request(2'($urandom_range(0, 3)), 1'b1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
